// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: decodes the immediate and format of each instruction
// and hands it downstream through a registered valid/ready output backed by one skid entry.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_C = 0,
  parameter int TAG_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_fmt,
  output logic             out_is_rvc,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] FMT_NONE  = 4'd0;
  localparam logic [3:0] FMT_I     = 4'd1;
  localparam logic [3:0] FMT_SHAMT = 4'd2;
  localparam logic [3:0] FMT_S     = 4'd3;
  localparam logic [3:0] FMT_B     = 4'd4;
  localparam logic [3:0] FMT_U     = 4'd5;
  localparam logic [3:0] FMT_J     = 4'd6;
  localparam logic [3:0] FMT_CI    = 4'd7;
  localparam logic [3:0] FMT_CLUI  = 4'd8;
  localparam logic [3:0] FMT_CJ    = 4'd9;
  localparam logic [3:0] FMT_CB    = 4'd10;
  localparam logic [3:0] FMT_CMEM  = 4'd11;

  logic [31:0]      imm32;
  logic             imm_sgn;
  logic [3:0]       dec_fmt;
  logic             dec_rvc;
  logic [XLEN-1:0]  dec_imm;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             shamt_hi;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [3:0]       skid_fmt;
  logic             skid_is_rvc;
  logic [TAG_W-1:0] skid_tag;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign shamt_hi = (XLEN == 64) ? in_instr[25] : 1'b0;

  // Every format is first formed as a 32-bit value, then widened to XLEN below.
  always_comb begin
    imm32   = '0;
    imm_sgn = 1'b0;
    dec_fmt = FMT_NONE;
    dec_rvc = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0000011, 7'b1100111: begin
          dec_fmt = FMT_I;
          imm_sgn = 1'b1;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0010011: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_fmt = FMT_SHAMT;
            imm32   = {26'b0, shamt_hi, in_instr[24:20]};
          end else begin
            dec_fmt = FMT_I;
            imm_sgn = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
              dec_fmt = FMT_SHAMT;
              imm32   = {27'b0, in_instr[24:20]};
            end else begin
              dec_fmt = FMT_I;
              imm_sgn = 1'b1;
              imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
          end
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          imm_sgn = 1'b1;
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          imm_sgn = 1'b1;
          imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          imm_sgn = 1'b1;
          imm32   = {in_instr[31:12], 12'b0};
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          imm_sgn = 1'b1;
          imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        end
        default: ;
      endcase
    end else if (ENABLE_C != 0) begin
      dec_rvc = 1'b1;
      case ({in_instr[1:0], in_instr[15:13]})
        5'b01_000, 5'b01_010: begin
          dec_fmt = FMT_CI;
          imm_sgn = 1'b1;
          imm32   = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
        end
        5'b01_011: begin
          // rd == x2 is c.addi16sp, which has no CLUI-shaped immediate.
          if (in_instr[11:7] != 5'd2) begin
            dec_fmt = FMT_CLUI;
            imm_sgn = 1'b1;
            imm32   = {{14{in_instr[12]}}, in_instr[12], in_instr[6:2], 12'b0};
          end
        end
        5'b01_101: begin
          dec_fmt = FMT_CJ;
          imm_sgn = 1'b1;
          imm32   = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9], in_instr[6],
                     in_instr[7], in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin
          dec_fmt = FMT_CB;
          imm_sgn = 1'b1;
          imm32   = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                     in_instr[11:10], in_instr[4:3], 1'b0};
        end
        5'b00_010, 5'b00_110: begin
          dec_fmt = FMT_CMEM;
          imm32   = {25'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b0};
        end
        5'b10_010: begin
          dec_fmt = FMT_CMEM;
          imm32   = {24'b0, in_instr[3:2], in_instr[12], in_instr[6:4], 2'b0};
        end
        5'b10_110: begin
          dec_fmt = FMT_CMEM;
          imm32   = {24'b0, in_instr[8:7], in_instr[12:9], 2'b0};
        end
        default: ;
      endcase
    end
    dec_imm = imm_sgn ? XLEN'($signed(imm32)) : XLEN'(imm32);
  end

  assign in_ready = !skid_valid;

  // The skid entry only fills when the output is stalled; it always drains before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_is_rvc  <= 1'b0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_fmt    <= FMT_NONE;
      skid_is_rvc <= 1'b0;
      skid_tag    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_imm    <= skid_imm;
        out_fmt    <= skid_fmt;
        out_is_rvc <= skid_is_rvc;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        out_valid  <= 1'b1;
        out_imm    <= dec_imm;
        out_fmt    <= dec_fmt;
        out_is_rvc <= dec_rvc;
        out_tag    <= in_tag;
      end else begin
        skid_valid  <= 1'b1;
        skid_imm    <= dec_imm;
        skid_fmt    <= dec_fmt;
        skid_is_rvc <= dec_rvc;
        skid_tag    <= in_tag;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an RV32 (no RVC) and an RV64 (with RVC) instance share
// one stimulus stream; a scoreboard per instance is fed by the driver and drained by a monitor.
module tb_imm_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic        in_ready_a, out_valid_a, out_is_rvc_a;
  logic [31:0] out_imm_a, out_tag_a;
  logic [3:0]  out_fmt_a;
  logic        in_ready_b, out_valid_b, out_is_rvc_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_tag_b;
  logic [3:0]  out_fmt_b;

  imm_decode_stage #(.XLEN(32), .ENABLE_C(0), .TAG_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_is_rvc(out_is_rvc_a), .out_tag(out_tag_a));

  imm_decode_stage #(.XLEN(64), .ENABLE_C(1), .TAG_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_is_rvc(out_is_rvc_b), .out_tag(out_tag_b));

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  fmt;
    logic        rvc;
    logic [31:0] tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] tag_ctr = 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: immediates assembled arithmetically from bit fields.
  function automatic longint fb(input logic [31:0] i, input int hi, input int lo);
    return longint'((i >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1));
  endfunction

  function automatic longint sx(input longint v, input int n);
    if (v >= (longint'(1) << (n - 1))) return v - (longint'(1) << n);
    return v;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] i, input bit x64, input bit enc);
    exp_t e;
    longint v = 0;
    int n = 0;
    longint op, f3, q, f;
    e.fmt = 4'd0; e.rvc = 1'b0; e.tag = '0;
    if (fb(i, 1, 0) == 3) begin
      op = fb(i, 6, 0); f3 = fb(i, 14, 12);
      if (op == 'h03 || op == 'h67) begin e.fmt = 1; v = fb(i, 31, 20); n = 12; end
      else if (op == 'h13 && (f3 == 1 || f3 == 5)) begin e.fmt = 2; v = fb(i, x64 ? 25 : 24, 20); end
      else if (op == 'h13) begin e.fmt = 1; v = fb(i, 31, 20); n = 12; end
      else if (op == 'h1B && x64 && (f3 == 1 || f3 == 5)) begin e.fmt = 2; v = fb(i, 24, 20); end
      else if (op == 'h1B && x64) begin e.fmt = 1; v = fb(i, 31, 20); n = 12; end
      else if (op == 'h23) begin e.fmt = 3; v = fb(i, 31, 25) * 32 + fb(i, 11, 7); n = 12; end
      else if (op == 'h63) begin
        e.fmt = 4; n = 13;
        v = fb(i, 31, 31) * 4096 + fb(i, 7, 7) * 2048 + fb(i, 30, 25) * 32 + fb(i, 11, 8) * 2;
      end
      else if (op == 'h37 || op == 'h17) begin e.fmt = 5; v = fb(i, 31, 12) * 4096; n = 32; end
      else if (op == 'h6F) begin
        e.fmt = 6; n = 21;
        v = fb(i, 31, 31) * (1 << 20) + fb(i, 19, 12) * 4096 + fb(i, 20, 20) * 2048 + fb(i, 30, 21) * 2;
      end
    end else if (enc) begin
      e.rvc = 1'b1; q = fb(i, 1, 0); f = fb(i, 15, 13);
      if (q == 1 && (f == 0 || f == 2)) begin e.fmt = 7; v = fb(i, 12, 12) * 32 + fb(i, 6, 2); n = 6; end
      else if (q == 1 && f == 3 && fb(i, 11, 7) != 2) begin
        e.fmt = 8; v = (fb(i, 12, 12) * 32 + fb(i, 6, 2)) * 4096; n = 18;
      end
      else if (q == 1 && f == 5) begin
        e.fmt = 9; n = 12;
        v = fb(i, 12, 12) * 2048 + fb(i, 8, 8) * 1024 + fb(i, 10, 9) * 256 + fb(i, 6, 6) * 128
          + fb(i, 7, 7) * 64 + fb(i, 2, 2) * 32 + fb(i, 11, 11) * 16 + fb(i, 5, 3) * 2;
      end
      else if (q == 1 && f >= 6) begin
        e.fmt = 10; n = 9;
        v = fb(i, 12, 12) * 256 + fb(i, 6, 5) * 64 + fb(i, 2, 2) * 32 + fb(i, 11, 10) * 8 + fb(i, 4, 3) * 2;
      end
      else if (q == 0 && (f == 2 || f == 6)) begin
        e.fmt = 11; v = fb(i, 5, 5) * 64 + fb(i, 12, 10) * 8 + fb(i, 6, 6) * 4;
      end
      else if (q == 2 && f == 2) begin
        e.fmt = 11; v = fb(i, 3, 2) * 64 + fb(i, 12, 12) * 32 + fb(i, 6, 4) * 4;
      end
      else if (q == 2 && f == 6) begin
        e.fmt = 11; v = fb(i, 8, 7) * 64 + fb(i, 12, 9) * 4;
      end
    end
    if (n != 0) v = sx(v, n);
    e.imm = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] imm, input logic [3:0] fmt, input logic rvc);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.rvc = rvc; e.tag = '0;
    return e;
  endfunction

  // Monitor: pops on each output handshake; a flush discards everything in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && flush) begin
      qa.delete();
      qb.delete();
    end else if (rst_n) begin
      if (out_valid_a && out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_output", 64'(out_tag_a), 64'hDEAD);
        else begin
          e = qa.pop_front();
          chk("a_imm", 64'(out_imm_a), e.imm);
          chk("a_fmt", 64'(out_fmt_a), 64'(e.fmt));
          chk("a_rvc", 64'(out_is_rvc_a), 64'(e.rvc));
          chk("a_tag", 64'(out_tag_a), 64'(e.tag));
        end
      end
      if (out_valid_b && out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_output", 64'(out_tag_b), 64'hDEAD);
        else begin
          e = qb.pop_front();
          chk("b_imm", out_imm_b, e.imm);
          chk("b_fmt", 64'(out_fmt_b), 64'(e.fmt));
          chk("b_rvc", 64'(out_is_rvc_b), 64'(e.rvc));
          chk("b_tag", 64'(out_tag_b), 64'(e.tag));
        end
      end
    end
  end

  // One clock of stimulus; called and returns at posedge+1.
  task automatic drive(input bit v, input logic [31:0] instr, input bit rdy, input bit fl,
                       input exp_t ea, input exp_t eb, output bit acc);
    in_valid = v; in_instr = instr; in_tag = tag_ctr; out_ready = rdy; flush = fl;
    @(negedge clk);
    acc = v && in_ready_a && !fl;
    if (acc) begin
      ea.tag = tag_ctr; eb.tag = tag_ctr;
      qa.push_back(ea); qb.push_back(eb);
      tag_ctr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input bit rdy, input bit fl);
    bit acc;
    drive(1'b0, 32'h0, rdy, fl, mk(0, 0, 0), mk(0, 0, 0), acc);
  endtask

  // Holds one instruction until accepted; rnd_rdy randomises downstream readiness.
  task automatic send(input logic [31:0] instr, input bit rnd_rdy);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 200) begin
      drive(1'b1, instr, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0,
            ref_dec(instr, 1'b0, 1'b0), ref_dec(instr, 1'b1, 1'b1), acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 64'(tries), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    else if (w[1:0] == 2'b11) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_a_out_valid"}, 64'(out_valid_a), 0);
    chk({nm, "_a_out_imm"}, 64'(out_imm_a), 0);
    chk({nm, "_a_out_fmt"}, 64'(out_fmt_a), 0);
    chk({nm, "_a_out_rvc"}, 64'(out_is_rvc_a), 0);
    chk({nm, "_a_out_tag"}, 64'(out_tag_a), 0);
    chk({nm, "_a_in_ready"}, 64'(in_ready_a), 1);
    chk({nm, "_b_out_valid"}, 64'(out_valid_b), 0);
    chk({nm, "_b_out_imm"}, out_imm_b, 0);
    chk({nm, "_b_out_fmt"}, 64'(out_fmt_b), 0);
    chk({nm, "_b_in_ready"}, 64'(in_ready_b), 1);
  endtask

  localparam int ND = 13;
  logic [31:0] d_ins [ND] = '{32'hFFF00093, 32'h4030D093, 32'h03F09093, 32'hFE000EE3,
                              32'hFF9FF06F, 32'h00008067, 32'h0000557D, 32'h123450B7,
                              32'h800000B7, 32'hFE112FA3, 32'hFFF0809B, 32'h00006105,
                              32'h00006505};
  logic [63:0] d_ia [ND] = '{64'hFFFFFFFF, 64'd3, 64'd31, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'd0,
                             64'd0, 64'h12345000, 64'h80000000, 64'hFFFFFFFF, 64'd0, 64'd0, 64'd0};
  logic [3:0]  d_fa [ND] = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd6, 4'd1, 4'd0, 4'd5, 4'd5, 4'd3, 4'd0,
                             4'd0, 4'd0};
  logic [63:0] d_ib [ND] = '{64'hFFFFFFFFFFFFFFFF, 64'd3, 64'd63, 64'hFFFFFFFFFFFFFFFC,
                             64'hFFFFFFFFFFFFFFF8, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h12345000,
                             64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                             64'd0, 64'h1000};
  logic [3:0]  d_fb [ND] = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd6, 4'd1, 4'd7, 4'd5, 4'd5, 4'd3, 4'd1,
                             4'd0, 4'd8};
  logic        d_rb [ND] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int nacc;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed words at full throughput.
    nacc = 0;
    for (int k = 0; k < ND; k++) begin
      drive(1'b1, d_ins[k], 1'b1, 1'b0, mk(d_ia[k], d_fa[k], 1'b0), mk(d_ib[k], d_fb[k], d_rb[k]), acc);
      if (acc) nacc++;
      if (k == 0) chk("latency_out_valid", 64'(out_valid_a), 1);
    end
    chk("full_throughput", 64'(nacc), 64'(ND));
    idle(1'b1, 1'b0); idle(1'b1, 1'b0);

    // Backpressure: A in output, B in skid, C held off.
    drive(1'b1, 32'h800000B7, 1'b0, 1'b0, ref_dec(32'h800000B7, 0, 0), ref_dec(32'h800000B7, 1, 1), acc);
    chk("bp_a_acc", 64'(acc), 1);
    drive(1'b1, 32'hFE112FA3, 1'b0, 1'b0, ref_dec(32'hFE112FA3, 0, 0), ref_dec(32'hFE112FA3, 1, 1), acc);
    chk("bp_b_acc", 64'(acc), 1);
    chk("bp_in_ready_low", 64'(in_ready_a), 0);
    chk("bp_out_valid", 64'(out_valid_a), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000557D, 1'b0, 1'b0, ref_dec(32'h0000557D, 0, 0), ref_dec(32'h0000557D, 1, 1), acc);
      chk("bp_c_held", 64'(acc), 0);
    end
    drive(1'b1, 32'h0000557D, 1'b1, 1'b0, ref_dec(32'h0000557D, 0, 0), ref_dec(32'h0000557D, 1, 1), acc);
    chk("bp_c_blocked_on_skid_move", 64'(acc), 0);
    drive(1'b1, 32'h0000557D, 1'b1, 1'b0, ref_dec(32'h0000557D, 0, 0), ref_dec(32'h0000557D, 1, 1), acc);
    chk("bp_c_acc", 64'(acc), 1);
    repeat (3) idle(1'b1, 1'b0);
    chk("bp_drained", 64'(qa.size() + qb.size()), 0);

    // Flush with both entries full and a word offered.
    send(32'h123450B7, 1'b0);
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, ref_dec(32'hFFF00093, 0, 0), ref_dec(32'hFFF00093, 1, 1), acc);
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b0, ref_dec(32'hFE000EE3, 0, 0), ref_dec(32'hFE000EE3, 1, 1), acc);
    chk("flush_pre_in_ready", 64'(in_ready_a), 0);
    drive(1'b1, 32'hFF9FF06F, 1'b0, 1'b1, ref_dec(32'hFF9FF06F, 0, 0), ref_dec(32'hFF9FF06F, 1, 1), acc);
    chk("flush_out_valid_a", 64'(out_valid_a), 0);
    chk("flush_out_valid_b", 64'(out_valid_b), 0);
    chk("flush_in_ready", 64'(in_ready_a), 1);
    repeat (3) idle(1'b1, 1'b0);

    // Randomised traffic with stalls, gaps and idle flushes.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 1), $urandom_range(0, 9) == 0);
      send(rand_instr(), 1'b1);
    end
    repeat (4) idle(1'b1, 1'b0);
    chk("random_drained", 64'(qa.size() + qb.size()), 0);

    // Asynchronous reset with both entries occupied.
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, ref_dec(32'hFFF00093, 0, 0), ref_dec(32'hFFF00093, 1, 1), acc);
    drive(1'b1, 32'h03F09093, 1'b0, 1'b0, ref_dec(32'h03F09093, 0, 0), ref_dec(32'h03F09093, 1, 1), acc);
    chk("rst_pre_out_valid", 64'(out_valid_a), 1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) send(rand_instr(), 1'b0);
    repeat (4) idle(1'b1, 1'b0);
    chk("final_drained", 64'(qa.size() + qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered immediate-decode stage between fetch and execute. Extracts and extends the immediate of each incoming instruction, classifies its format, and passes it downstream through a valid/ready handshake with a two-entry skid buffer. Generalises the earlier combinational decoder: parametrised XLEN (RV32/RV64), optional RVC immediate formats, JALR and OP-IMM-32 coverage, flush support.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ENABLE_C, 0, 1 = decode RVC immediates when in_instr[1:0] != 2'b11.
TAG_W, 32, width of the opaque sideband tag (typically the PC).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous pipeline flush.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  stage can accept; equals !skid_valid.
in_instr  input  32  instruction word; RVC in bits [15:0].
in_tag  input  TAG_W  sideband carried alongside.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  4  format: 0 NONE, 1 I, 2 SHAMT, 3 S, 4 B, 5 U, 6 J, 7 CI, 8 CLUI, 9 CJ, 10 CB, 11 CMEM.
out_is_rvc  output  1  entry was a compressed instruction.
out_tag  output  TAG_W  tag of the entry.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid_valid=0, out_imm=0, out_fmt=0, out_is_rvc=0, out_tag=0; in_ready=1. Reset mid-transfer discards both entries.
- Decode is combinational on the input; the result is registered. Latency 1 cycle from acceptance to out_valid.
- Accept when in_valid && in_ready. Output register empty or out_ready high: data goes to output register. Else: goes to skid. out_valid && out_ready with skid full: skid moves to output, new input not accepted (in_ready=0). Order strictly preserved; full throughput with out_ready held high.
- flush: next edge clears out_valid and skid_valid; any input offered in the flush cycle is dropped; flush overrides accept and transfer.
- 32-bit formats, opcode[6:0]:
  LOAD 0000011, JALR 1100111, OP-IMM 0010011 (non-shift): I; sext(instr[31:20]).
  OP-IMM with funct3 001 or 101: SHAMT; zext of instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  OP-IMM-32 0011011: XLEN=64 only; funct3 001/101 -> SHAMT zext(instr[24:20]), else I. XLEN=32: NONE.
  STORE 0100011: S; sext({instr[31:25],instr[11:7]}).
  BRANCH 1100011: B; sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  LUI 0110111, AUIPC 0010111: U; sext({instr[31:12],12'b0}) to XLEN.
  JAL 1101111: J; sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  Anything else: NONE, imm 0.
- RVC (ENABLE_C=1, in_instr[1:0] != 11), out_is_rvc=1, q=instr[1:0], f=instr[15:13]:
  q01 f000/010: CI; sext({i[12],i[6:2]}).
  q01 f011, rd != x2: CLUI; sext({i[12],i[6:2],12'b0}). rd = x2: NONE.
  q01 f101: CJ; sext({i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],1'b0}).
  q01 f110/111: CB; sext({i[12],i[6:5],i[2],i[11:10],i[4:3],1'b0}).
  q00 f010/110: CMEM; zext({i[5],i[12:10],i[6],2'b0}).
  q10 f010: CMEM; zext({i[3:2],i[12],i[6:4],2'b0}).
  q10 f110: CMEM; zext({i[8:7],i[12:9],2'b0}).
  Other RVC: NONE, imm 0.
- ENABLE_C=0: in_instr[1:0] != 11 yields NONE, out_is_rvc=0.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- srai x1,x1,3 (0x4030D093) -> imm 3, fmt SHAMT; XLEN=64 slli x1,x1,63 (0x03F09093) -> imm 63.
- beq x0,x0,-4 (0xFE000EE3) -> 0xFFFFFFFC fmt B; jal x0,-8 (0xFF9FF06F) -> 0xFFFFFFF8 fmt J; jalr (0x00008067) -> imm 0 fmt I.
- out_ready=0, push A,B,C back-to-back -> A in output, B in skid, in_ready=0, C held; release out_ready -> A,B,C emerge in order, no loss or duplication.
- ENABLE_C=1, c.li a0,-1 (0x557D) -> imm 0xFFFFFFFF, fmt CI, out_is_rvc=1; ENABLE_C=0 same word -> fmt NONE, imm 0.
- Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word absent; rst_n pulse mid-stream -> all outputs 0 immediately, no clock edge required.
